prog_strobe_gen: RTL and testbench
==================================

// Module: prog_strobe_gen
// PURPOSE
//   N-channel programmable strobe generator, successor to the fixed-rate strobe source.
//   Each channel emits single-cycle strobes with a runtime-writable period in clk_i cycles.
//   Modes per channel: periodic or one-shot.
//   Feeds game-tick, ball-speed and blink timers from one shared timing block.
// PARAMETERS
//   N_CH        4                             number of independent channels (>=1)
//   CNT_W       32                            period / counter width in bits
//   DEF_PERIOD  `BOARD_CLK_MHZ*1_000_000      reset period of every channel, in cycles (1 Hz)
// PORTS
//   clk_i         in   1                      system clock
//   rst_ni        in   1                      reset, asynchronous, active-low
//   en_i          in   N_CH                   per-channel enable (level)
//   mode_i        in   N_CH                   0 = periodic, 1 = one-shot
//   trig_i        in   N_CH                   one-shot start request (pulse)
//   sync_i        in   1                      phase-align: restart all running counters
//   cfg_we_i      in   1                      period write strobe
//   cfg_ch_i      in   max(1,$clog2(N_CH))    target channel of write
//   cfg_period_i  in   CNT_W                  new period P, in cycles
//   strobe_o      out  N_CH                   one-cycle strobe, registered
//   busy_o        out  N_CH                   channel in RUN state
// BEHAVIOUR
//   - Reset (rst_ni low, async): strobe_o=0, busy_o=0, cnt=0.
//     Active and shadow period = DEF_PERIOD. All channels in IDLE.
//   - Per-channel FSM states: IDLE, RUN_P (periodic), RUN_1 (one-shot).
//   - mode_i is sampled only on leaving IDLE. Changes while running are ignored until IDLE.
//   - IDLE->RUN_P: en_i=1 and mode_i=0.
//   - IDLE->RUN_1: en_i=1, mode_i=1 and trig_i=1.
//   - trig_i in RUN_1 or RUN_P is ignored.
//   - Entry edge: cnt<=0.
//   - RUN: cnt increments each cycle. At cnt==P-1: cnt<=0 and strobe_o<=1 for exactly 1 cycle.
//   - Strobe latency: first strobe_o high P cycles after the entry edge. Periodic channels repeat every P.
//   - RUN_1: after its single strobe, returns to IDLE. busy_o drops in the same cycle strobe_o is high.
//   - en_i=0 in any RUN state: channel goes to IDLE at that edge and cnt<=0.
//     No strobe at that edge, even if cnt==P-1.
//   - P==1: in RUN_P, strobe_o is high every cycle from entry+1. In RUN_1, one strobe at entry+1.
//   - P==0: channel may enter RUN (busy_o=1) but never strobes. cnt stays 0.
//   - sync_i=1: every RUN channel cnt<=0. No strobe at that edge, even at wrap.
//     sync_i has priority over wrap. en_i=0 has priority over sync_i.
//   - cfg write: cfg_we_i=1 writes cfg_period_i to shadow[cfg_ch_i]. Writes with cfg_ch_i>=N_CH are dropped.
//   - Active period loads from shadow:
//       in IDLE, every cycle;
//       in RUN, only on a wrap edge (cnt==P-1) or a sync_i edge.
//     A write in the same cycle as the load is bypassed, so the new value loads.
//     Mid-period writes never shorten or stretch the current period.
//   - Counter compare uses the active period, CNT_W bits, unsigned. cnt never exceeds P-1.
// STRUCTURE
//   - strobe_pkg holds:
//       typedef enum logic[1:0] {IDLE, RUN_P, RUN_1} strobe_state_t;
//       typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} strobe_mode_t;
//       localparam for the DEF_PERIOD computation.
//   - Sub-module strobe_channel (one per channel, generate loop). It contains the FSM, cnt,
//     the active/shadow period registers and the bypass.
//   - The top holds only the cfg_ch_i decode and sync_i fan-out.
// TESTING
//   1. Reset defaults: DEF_PERIOD overridden to 10. en_i[0]=1, mode periodic.
//      -> strobe_o[0] pulses at cycles 10, 20, 30 after the enable edge. Pulse width 1.
//   2. Period write mid-run: P=10 running, write P=4 at cnt=3.
//      -> next strobe still at cnt wrap (cycle 10). Then every 4 cycles.
//   3. One-shot: write P=5, mode_i=1, en_i=1, trig at edge T.
//      -> single strobe at T+5, busy_o high T+1..T+4. Retrigger at T+2 ignored.
//   4. Disable at wrap: P=6, drop en_i on the edge where cnt==5.
//      -> no strobe, busy_o=0. Re-enable -> first strobe 6 cycles later.
//   5. sync_i: ch0 P=8, ch1 P=8 started 3 cycles apart. Pulse sync_i.
//      -> both strobe 8 cycles after sync, coincident, no strobe on the sync edge.
//   6. Edge cases: P=1 gives strobe every cycle. P=0 gives busy, no strobes.
//      cfg_ch_i=N_CH write changes nothing. Async reset mid-run clears all outputs without a clock edge.

Source files
------------

// File: rtl/strobe_pkg.sv
// Shared types and constants for the programmable strobe generator.
//   strobe_state_t : per-channel FSM state
//   strobe_mode_t  : meaning of one mode_i bit
//   DEF_PERIOD_CYC : reset period of every channel, one second of board clock

`ifndef BOARD_CLK_MHZ
`define BOARD_CLK_MHZ 50
`endif

package strobe_pkg;

    typedef enum logic [1:0] {IDLE, RUN_P, RUN_1} strobe_state_t;
    typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} strobe_mode_t;

    localparam int unsigned BOARD_CLK_MHZ  = `BOARD_CLK_MHZ;
    localparam int unsigned DEF_PERIOD_CYC = BOARD_CLK_MHZ * 1_000_000;

endpackage

// File: rtl/strobe_channel.sv
// One strobe channel: FSM, cycle counter, shadow/active period registers.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   en_i            channel enable (level)
//   mode_i          0 = periodic, 1 = one-shot (sampled when leaving IDLE)
//   trig_i          one-shot start request
//   sync_i          restart the counter if running
//   cfg_we_i        write cfg_period_i into the shadow period
//   cfg_period_i    new period in cycles
//   strobe_o        registered single-cycle strobe
//   busy_o          channel is in a RUN state

module strobe_channel
    import strobe_pkg::*;
#(
    parameter int unsigned      CNT_W      = 32,
    parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEF_PERIOD_CYC)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             trig_i,
    input  logic             sync_i,
    input  logic             cfg_we_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    output logic             strobe_o,
    output logic             busy_o
);

    strobe_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_act_q, per_act_d;
    logic [CNT_W-1:0] per_sh_q, per_sh_d;
    logic             strobe_q, strobe_d;
    logic             wrap;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            per_act_q <= DEF_PERIOD;
            per_sh_q  <= DEF_PERIOD;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_act_q <= per_act_d;
            per_sh_q  <= per_sh_d;
            strobe_q  <= strobe_d;
        end
    end

    always_comb begin
        // A write landing on a load edge goes straight into the active period.
        per_sh_d  = cfg_we_i ? cfg_period_i : per_sh_q;
        // P==0 never wraps; the guard also keeps P-1 from underflowing into a match.
        wrap      = (per_act_q != '0) && (cnt_q == per_act_q - CNT_W'(1));
        state_d   = state_q;
        cnt_d     = cnt_q;
        per_act_d = per_act_q;
        strobe_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d     = '0;
                per_act_d = per_sh_d;
                if (en_i) begin
                    if (strobe_mode_t'(mode_i) == MODE_PERIODIC) begin
                        state_d = RUN_P;
                    end else if (trig_i) begin
                        state_d = RUN_1;
                    end
                end
            end
            RUN_P, RUN_1: begin
                if (!en_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (sync_i) begin
                    cnt_d     = '0;
                    per_act_d = per_sh_d;
                end else if (wrap) begin
                    cnt_d     = '0;
                    strobe_d  = 1'b1;
                    per_act_d = per_sh_d;
                    if (state_q == RUN_1) begin
                        state_d = IDLE;
                    end
                end else if (per_act_q == '0) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign strobe_o = strobe_q;
    assign busy_o   = (state_q != IDLE);

endmodule

// File: rtl/prog_strobe_gen.sv
// N-channel programmable strobe generator.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   en_i            per-channel enable
//   mode_i          per-channel mode (0 periodic, 1 one-shot)
//   trig_i          per-channel one-shot start request
//   sync_i          restart all running counters
//   cfg_we_i        period write strobe
//   cfg_ch_i        channel addressed by the write (out-of-range writes dropped)
//   cfg_period_i    new period in cycles
//   strobe_o        per-channel registered single-cycle strobe
//   busy_o          per-channel RUN indication

module prog_strobe_gen
    import strobe_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned DEF_PERIOD = DEF_PERIOD_CYC,
    localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_CH-1:0]  en_i,
    input  logic [N_CH-1:0]  mode_i,
    input  logic [N_CH-1:0]  trig_i,
    input  logic             sync_i,
    input  logic             cfg_we_i,
    input  logic [CH_W-1:0]  cfg_ch_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    output logic [N_CH-1:0]  strobe_o,
    output logic [N_CH-1:0]  busy_o
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Decoding only the existing channel indices drops out-of-range writes.
        logic ch_we;
        assign ch_we = cfg_we_i && (cfg_ch_i == CH_W'(i));

        strobe_channel #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (CNT_W'(DEF_PERIOD))
        ) u_ch (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .en_i         (en_i[i]),
            .mode_i       (mode_i[i]),
            .trig_i       (trig_i[i]),
            .sync_i       (sync_i),
            .cfg_we_i     (ch_we),
            .cfg_period_i (cfg_period_i),
            .strobe_o     (strobe_o[i]),
            .busy_o       (busy_o[i])
        );
    end

endmodule

// File: tb/tb_prog_strobe_gen.sv
// Directed bench for prog_strobe_gen (3 channels, reset period 10).

module tb_prog_strobe_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  en, mode, trig;
    logic        sync;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_period;
    logic [2:0]  strobe, busy;

    int unsigned ncmp = 0;
    int unsigned nfail = 0;

    prog_strobe_gen #(
        .N_CH       (3),
        .CNT_W      (32),
        .DEF_PERIOD (10)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .mode_i       (mode),
        .trig_i       (trig),
        .sync_i       (sync),
        .cfg_we_i     (cfg_we),
        .cfg_ch_i     (cfg_ch),
        .cfg_period_i (cfg_period),
        .strobe_o     (strobe),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [31:0] p);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_period = p;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en = '0; mode = '0; trig = '0; sync = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        #12;
        chk("rst_strobe", strobe, 3'b000);
        chk("rst_busy", busy, 3'b000);
        rst_n = 1'b1;
        step();

        // 1: default period 10, periodic on ch0
        en[0] = 1'b1;
        step();
        chk("t1_busy_entry", busy[0], 1);
        chk("t1_strobe_entry", strobe[0], 0);
        for (int k = 1; k <= 30; k++) begin
            step();
            chk("t1_strobe", strobe[0], (k % 10 == 0));
        end

        // 2: write P=4 while cnt==3; current period stays 10
        for (int k = 31; k <= 48; k++) begin
            if (k == 34) begin
                cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 4;
            end
            step();
            cfg_we = 1'b0;
            chk("t2_strobe", strobe[0], (k == 40 || k == 44 || k == 48));
        end
        en[0] = 1'b0;
        step();

        // 3: one-shot P=5 on ch1, retrigger ignored
        cfg_write(2'd1, 5);
        en[1] = 1'b1; mode[1] = 1'b1; trig[1] = 1'b1;
        step();
        trig[1] = 1'b0;
        chk("t3_busy_entry", busy[1], 1);
        for (int k = 1; k <= 6; k++) begin
            if (k == 2) trig[1] = 1'b1;
            step();
            trig[1] = 1'b0;
            chk("t3_strobe", strobe[1], (k == 5));
            chk("t3_busy", busy[1], (k < 5));
        end
        en[1] = 1'b0; mode[1] = 1'b0;

        // 4: disable on the wrap edge, then re-enable
        cfg_write(2'd2, 6);
        en[2] = 1'b1;
        step();
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t4_pre_strobe", strobe[2], 0);
        end
        en[2] = 1'b0;
        step();
        chk("t4_dis_strobe", strobe[2], 0);
        chk("t4_dis_busy", busy[2], 0);
        en[2] = 1'b1;
        step();
        chk("t4_reen_busy", busy[2], 1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t4_reen_strobe", strobe[2], (k == 6));
        end
        en[2] = 1'b0;
        step();

        // 5: sync aligns two channels started 3 cycles apart
        cfg_write(2'd0, 8);
        cfg_write(2'd1, 8);
        en[0] = 1'b1;
        step(); step(); step();
        en[1] = 1'b1;
        step(); step(); step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("t5_sync_edge", strobe[1:0], 2'b00);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t5_strobe", strobe[1:0], (k == 8) ? 2'b11 : 2'b00);
        end
        en[1:0] = 2'b00;
        step();

        // 6a: P=1 strobes every cycle from entry+1
        cfg_write(2'd2, 1);
        en[2] = 1'b1;
        step();
        chk("t6_p1_entry", strobe[2], 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t6_p1_strobe", strobe[2], 1);
        end
        en[2] = 1'b0;
        step();
        chk("t6_p1_off", strobe[2], 0);

        // 6b: P=0 is busy but silent
        cfg_write(2'd2, 0);
        en[2] = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("t6_p0_busy", busy[2], 1);
            chk("t6_p0_strobe", strobe[2], 0);
        end
        en[2] = 1'b0;
        step();

        // 6c: out-of-range channel write leaves ch0/ch1 at 8
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 2;
        step();
        cfg_we = 1'b0;
        en[1:0] = 2'b11;
        step();
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t6_oor_strobe", strobe[1:0], (k == 8) ? 2'b11 : 2'b00);
        end

        // 6d: async reset clears outputs between edges, restores period 10
        #2 rst_n = 1'b0;
        #1;
        chk("t6_arst_strobe", strobe, 3'b000);
        chk("t6_arst_busy", busy, 3'b000);
        en = '0;
        #3 rst_n = 1'b1;
        step();
        en[0] = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("t6_def_strobe", strobe[0], (k == 10));
        end
        en[0] = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
